// File: rtl/ahb_pkg.sv
// Purpose: shared AHB-Lite encodings and the common slave FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HSIZE encodings
    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    // HRESP encodings
    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    // Slave data-phase state machine, common to all AHB slaves in this family
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } ahb_slv_state_t;

endpackage

// File: rtl/ahb_byte_strobe_gen.sv
// Purpose: byte-lane strobe and alignment check from HSIZE and address byte offset.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: size (HSIZE), offset (address low bits) -> strb (one bit per lane,
//        lane n = byte offset n, little-endian), misalign (offset not a multiple of size).
module ahb_byte_strobe_gen
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]                      size,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
    output logic [DATA_WIDTH/8-1:0]         strb,
    output logic                            misalign
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int OW = $clog2(NB);

    logic [NB-1:0] lanes;
    logic [OW-1:0] align_mask;

    always_comb begin
        lanes      = '1;
        align_mask = '1;
        case (size)
            HSIZE_BYTE: begin
                lanes      = NB'(8'h01);
                align_mask = '0;
            end
            HSIZE_HALF: begin
                lanes      = NB'(8'h03);
                align_mask = OW'(3'd1);
            end
            HSIZE_WORD: begin
                lanes      = NB'(8'h0F);
                align_mask = OW'(3'd3);
            end
            HSIZE_DWORD: begin
                lanes      = NB'(8'hFF);
                align_mask = OW'(3'd7);
            end
            default: begin
                lanes      = '1;
                align_mask = '1;
            end
        endcase
        strb     = lanes << offset;
        misalign = |(offset & align_mask);
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// Purpose: AHB-Lite slave over a word-addressed SRAM with byte/half/word lanes and 2-cycle ERROR.
// Latency: WAIT_STATES cycles with readyout low, then one completion cycle after the address edge.
// Backpressure: holds readyout low during wait states and ERR1; address phases taken only when ready is high.
// Ports: ahb_clk_in/ahb_rst_in (async, active-high); ahb_sel/addr/trans/write/size_in address phase;
//        ahb_wdata_in data phase; ahb_ready_in bus HREADY; ahb_rdata/readyout/resp_out slave response.
// Optional: define AHB_SRAM_SLAVE_RO_REGION_EN to make word indices 0..RO_WORDS-1 read-only.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int AHB_DATA_WIDTH = 32,
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int MEM_DEPTH      = 256,
    parameter int WAIT_STATES    = 1,
    parameter int RO_WORDS       = 16
) (
    input  logic                      ahb_clk_in,
    input  logic                      ahb_rst_in,
    input  logic                      ahb_sel_in,
    input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
    input  logic [1:0]                ahb_trans_in,
    input  logic                      ahb_write_in,
    input  logic [2:0]                ahb_size_in,
    input  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in,
    input  logic                      ahb_ready_in,
    output logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out,
    output logic                      ahb_readyout_out,
    output logic                      ahb_resp_out
);

    localparam int         NB       = AHB_DATA_WIDTH / 8;
    localparam int         OW       = $clog2(NB);
    localparam int         XW       = AHB_ADDR_WIDTH - OW;   // full word-index width
    localparam int         IW       = $clog2(MEM_DEPTH);
    localparam logic [2:0] MAX_SIZE = 3'(OW);
    localparam logic [3:0] WS       = 4'(WAIT_STATES);

`ifdef AHB_SRAM_SLAVE_RO_REGION_EN
    localparam bit RO_EN = 1'b1;
`else
    localparam bit RO_EN = 1'b0;
`endif

    // Address-phase decode
    logic [XW-1:0] word_idx;
    logic [OW-1:0] byte_off;
    logic [NB-1:0] strb;
    logic          misalign;
    logic          active;
    logic          accept;
    logic          illegal;

    assign word_idx = ahb_addr_in[AHB_ADDR_WIDTH-1:OW];
    assign byte_off = ahb_addr_in[OW-1:0];

    ahb_byte_strobe_gen #(
        .DATA_WIDTH (AHB_DATA_WIDTH)
    ) u_strobe (
        .size     (ahb_size_in),
        .offset   (byte_off),
        .strb     (strb),
        .misalign (misalign)
    );

    always_comb begin
        active = 1'b0;
        case (ahb_trans_in)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            default:                   active = 1'b0;
        endcase
    end

    assign accept  = ahb_sel_in && ahb_ready_in && active;
    assign illegal = (word_idx >= XW'(MEM_DEPTH))
                   || (ahb_size_in > MAX_SIZE)
                   || misalign
                   || (RO_EN && ahb_write_in && (word_idx < XW'(RO_WORDS)));

    // Data-phase state; strobes are derived at the address phase so the
    // captured offset and size travel as a lane mask.
    ahb_slv_state_t state_q;
    logic [3:0]     wait_cnt_q;
    logic           readyout_q;
    logic           resp_q;
    logic           write_q;
    logic [IW-1:0]  idx_q;
    logic [NB-1:0]  strb_q;

    always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
        if (ahb_rst_in) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            readyout_q <= 1'b1;
            resp_q     <= RESP_OKAY;
            write_q    <= 1'b0;
            idx_q      <= '0;
            strb_q     <= '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (wait_cnt_q == 4'd1) begin
                        state_q    <= ST_DATA;
                        wait_cnt_q <= '0;
                        readyout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state_q    <= ST_ERR2;
                    readyout_q <= 1'b1;
                    resp_q     <= RESP_ERROR;
                end
                default: begin
                    // IDLE, DATA and ERR2 all drive ready high, so a new
                    // address phase can be taken here (pipelined transfers).
                    state_q    <= ST_IDLE;
                    readyout_q <= 1'b1;
                    resp_q     <= RESP_OKAY;
                    if (accept) begin
                        if (illegal) begin
                            state_q    <= ST_ERR1;
                            readyout_q <= 1'b0;
                            resp_q     <= RESP_ERROR;
                        end else begin
                            write_q <= ahb_write_in;
                            idx_q   <= word_idx[IW-1:0];
                            strb_q  <= strb;
                            if (WAIT_STATES == 0) begin
                                state_q <= ST_DATA;
                            end else begin
                                state_q    <= ST_WAIT;
                                wait_cnt_q <= WS;
                                readyout_q <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Storage is not reset. Writes commit at the end of the DATA cycle, so a
    // read accepted in that same cycle already sees the new contents.
    logic [AHB_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge ahb_clk_in) begin
        if (state_q == ST_DATA && write_q) begin
            for (int i = 0; i < NB; i++) begin
                if (strb_q[i]) begin
                    mem[idx_q][8*i +: 8] <= ahb_wdata_in[8*i +: 8];
                end
            end
        end
    end

    // Read data depends only on registered state and the array, never on bus inputs.
    assign ahb_rdata_out    = (state_q == ST_DATA && !write_q) ? mem[idx_q] : '0;
    assign ahb_readyout_out = readyout_q;
    assign ahb_resp_out     = resp_q;

endmodule
